// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word definitions for the CPU controller front end:
// sequencer states, ALU op encodings and control-word field positions.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b11;

  localparam int ALU_SEL_HI = 3;
  localparam int ALU_SEL_LO = 2;
  localparam int MUX_BIT    = 1;
  localparam int LOAD_BIT   = 0;

  // Terminates a program; the word itself is never executed.
  localparam logic [3:0] HALT_WORD = 4'b0000;

endpackage

// File: rtl/cpu_sequencer_decode.sv
// Combinational split of a latched control word into its datapath fields.
module ctrl_word_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] instr,
  output logic [1:0] alu_sel,
  output logic       mux_sel,
  output logic       load_raw
);

  assign alu_sel  = instr[ALU_SEL_HI:ALU_SEL_LO];
  assign mux_sel  = instr[MUX_BIT];
  assign load_raw = instr[LOAD_BIT];

endmodule

// File: rtl/cpu_sequencer.sv
// Microsequencer: walks the PC through the control ROM on a start/done
// handshake, latching each word and gating its load with the datapath stall.
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int WORD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [1:0]        alu_sel,
  output logic              mux_sel,
  output logic              load,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  seq_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [WORD_W-1:0] instr_reg, instr_next;
  logic              load_raw;

  ctrl_word_decode u_decode (
    .instr    (instr_reg),
    .alu_sel  (alu_sel),
    .mux_sel  (mux_sel),
    .load_raw (load_raw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      instr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        pc_next = '0;
        if (start) state_next = FETCH;
      end
      FETCH: begin
        busy       = 1'b1;
        instr_next = rom_data;
        state_next = (rom_data == HALT_WORD) ? DONE : EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        // A stalled word is simply re-presented next cycle with its fields held.
        if (!stall) begin
          load = load_raw;
          if (pc_reg == PC_LAST) begin
            state_next = DONE;
          end else begin
            pc_next    = pc_reg + 1'b1;
            state_next = FETCH;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        pc_next    = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rom_addr = pc_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a ROM model feeds the DUT and each
// scenario task compares recorded per-cycle outputs with hand-derived values.
module tb_cpu_sequencer;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] rom_addr;
  logic [3:0] rom_data;
  logic [1:0] alu_sel;
  logic       mux_sel, load, busy, done;

  logic [3:0] rom [8];
  int total = 0;
  int bad = 0;

  // Per-cycle record of one run, indexed by cycle number (start sampled at edge 0).
  logic       c_load [64];
  logic [1:0] c_alu  [64];
  logic       c_mux  [64];
  logic       c_busy [64];
  logic       c_done [64];
  logic [2:0] c_addr [64];

  logic [1:0] prog_alu [7] = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11};
  logic       prog_mux [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  cpu_sequencer #(.ADDR_W(3), .WORD_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stall    (stall),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .alu_sel  (alu_sel),
    .mux_sel  (mux_sel),
    .load     (load),
    .busy     (busy),
    .done     (done)
  );

  task automatic set_rom(input logic [31:0] w);
    for (int i = 0; i < 8; i++) rom[i] = w[4*i +: 4];
  endtask

  // Pulse start (sampled at edge 0) and record cycles 1..ncyc.
  task automatic run(input int st_from, input int st_len, input int restart_at,
                     input int rst_at, input int ncyc);
    for (int c = 0; c < 64; c++) begin
      c_load[c] = 1'b0; c_alu[c] = 2'b00; c_mux[c] = 1'b0;
      c_busy[c] = 1'b0; c_done[c] = 1'b0; c_addr[c] = 3'd0;
    end
    @(posedge clk); #1;
    start = 1'b1; stall = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      stall = (c >= st_from) && (c < st_from + st_len);
      start = (c == restart_at);
      rst_n = (c != rst_at);
      @(negedge clk);
      c_load[c] = load; c_alu[c] = alu_sel; c_mux[c] = mux_sel;
      c_busy[c] = busy; c_done[c] = done;   c_addr[c] = rom_addr;
      if (load) $display("  cycle %0d: load alu_sel=%b mux_sel=%b addr=%0d", c, alu_sel, mux_sel, rom_addr);
      if (done) $display("  cycle %0d: done", c);
      @(posedge clk); #1;
    end
    stall = 1'b0; start = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset;
    $display("test_reset");
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({rom_addr, alu_sel, mux_sel, load, busy, done} !== 9'b0) begin
        bad++;
        $display("FAIL reset_idle c%0d: got addr=%0d alu=%b mux=%b load=%b busy=%b done=%b, need all 0",
                 c, rom_addr, alu_sel, mux_sel, load, busy, done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_program(input int restart_at);
    logic exp_ld;
    int c;
    $display("test_full_program restart_at=%0d", restart_at);
    set_rom(32'h0D9F_FD91);
    run(0, 0, restart_at, -1, 20);
    for (int i = 1; i <= 20; i++) begin
      exp_ld = (i % 2 == 0) && (i <= 14);
      total++;
      if (c_load[i] !== exp_ld) begin
        bad++; $display("FAIL full_load c%0d: got %b need %b", i, c_load[i], exp_ld);
      end
      total++;
      if (c_done[i] !== (i == 16)) begin
        bad++; $display("FAIL full_done c%0d: got %b need %b", i, c_done[i], (i == 16));
      end
    end
    for (int k = 0; k < 7; k++) begin
      c = 2 * k + 2;
      total++;
      if ({c_alu[c], c_mux[c]} !== {prog_alu[k], prog_mux[k]}) begin
        bad++; $display("FAIL full_fields addr%0d: got alu=%b mux=%b need alu=%b mux=%b",
                        k, c_alu[c], c_mux[c], prog_alu[k], prog_mux[k]);
      end
    end
    total++;
    if ({c_addr[15], c_busy[15], c_busy[16]} !== {3'd7, 1'b1, 1'b0}) begin
      bad++; $display("FAIL full_tail: got addr15=%0d busy15=%b busy16=%b need 7 1 0",
                      c_addr[15], c_busy[15], c_busy[16]);
    end
  endtask

  task automatic test_stall;
    logic exp_ld;
    $display("test_stall");
    set_rom(32'h0D9F_FD91);
    run(8, 3, -1, -1, 22);
    for (int i = 1; i <= 22; i++) begin
      exp_ld = ((i % 2 == 0) && (i <= 6)) || ((i % 2 == 1) && (i >= 11) && (i <= 17));
      total++;
      if (c_load[i] !== exp_ld) begin
        bad++; $display("FAIL stall_load c%0d: got %b need %b", i, c_load[i], exp_ld);
      end
      total++;
      if (c_done[i] !== (i == 19)) begin
        bad++; $display("FAIL stall_done c%0d: got %b need %b", i, c_done[i], (i == 19));
      end
    end
    for (int i = 8; i <= 11; i++) begin
      total++;
      if ({c_alu[i], c_mux[i], c_addr[i], c_busy[i]} !== {2'b11, 1'b1, 3'd3, 1'b1}) begin
        bad++; $display("FAIL stall_hold c%0d: got alu=%b mux=%b addr=%0d busy=%b need 11 1 3 1",
                        i, c_alu[i], c_mux[i], c_addr[i], c_busy[i]);
      end
    end
  endtask

  task automatic test_last_address;
    logic exp_ld;
    $display("test_last_address");
    set_rom(32'hDDDD_DDDD);
    run(0, 0, -1, -1, 20);
    for (int i = 1; i <= 20; i++) begin
      exp_ld = (i % 2 == 0) && (i <= 16);
      total++;
      if (c_load[i] !== exp_ld) begin
        bad++; $display("FAIL last_load c%0d: got %b need %b", i, c_load[i], exp_ld);
      end
      total++;
      if (c_done[i] !== (i == 17)) begin
        bad++; $display("FAIL last_done c%0d: got %b need %b", i, c_done[i], (i == 17));
      end
    end
    total++;
    if ({c_addr[16], c_addr[17], c_addr[18], c_busy[18]} !== {3'd7, 3'd7, 3'd0, 1'b0}) begin
      bad++; $display("FAIL last_pc: got addr16=%0d addr17=%0d addr18=%0d busy18=%b need 7 7 0 0",
                      c_addr[16], c_addr[17], c_addr[18], c_busy[18]);
    end
    total++;
    if ({c_alu[16], c_mux[16]} !== {ALU_ADD, 1'b0}) begin
      bad++; $display("FAIL last_fields: got alu=%b mux=%b need 11 0", c_alu[16], c_mux[16]);
    end
  endtask

  task automatic test_early_halt;
    $display("test_early_halt");
    set_rom(32'hDDDD_DDD0);
    run(0, 0, -1, -1, 6);
    for (int i = 1; i <= 6; i++) begin
      total++;
      if ({c_load[i], c_done[i]} !== {1'b0, (i == 2)}) begin
        bad++; $display("FAIL halt c%0d: got load=%b done=%b need 0 %b", i, c_load[i], c_done[i], (i == 2));
      end
    end
    total++;
    if ({c_busy[1], c_busy[2], c_busy[3]} !== 3'b100) begin
      bad++; $display("FAIL halt_busy: got %b%b%b need 100", c_busy[1], c_busy[2], c_busy[3]);
    end
  endtask

  task automatic test_start_in_done;
    $display("test_start_in_done");
    set_rom(32'h0D9F_FD91);
    run(0, 0, 16, -1, 20);
    for (int i = 17; i <= 20; i++) begin
      total++;
      if ({c_busy[i], c_load[i], c_done[i], c_addr[i]} !== 6'b0) begin
        bad++; $display("FAIL done_start c%0d: got busy=%b load=%b done=%b addr=%0d need idle",
                        i, c_busy[i], c_load[i], c_done[i], c_addr[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    $display("test_reset_mid_run");
    set_rom(32'h0D9F_FD91);
    run(6, 3, -1, 6, 12);
    total++;
    if ({c_load[6], c_alu[6], c_busy[6], c_addr[6]} !== {1'b0, 2'b11, 1'b1, 3'd2}) begin
      bad++; $display("FAIL rst_pre: got load=%b alu=%b busy=%b addr=%0d need 0 11 1 2",
                      c_load[6], c_alu[6], c_busy[6], c_addr[6]);
    end
    for (int i = 7; i <= 12; i++) begin
      total++;
      if ({c_load[i], c_busy[i], c_done[i], c_addr[i], c_alu[i], c_mux[i]} !== 9'b0) begin
        bad++; $display("FAIL rst_idle c%0d: got load=%b busy=%b done=%b addr=%0d alu=%b mux=%b need all 0",
                        i, c_load[i], c_busy[i], c_done[i], c_addr[i], c_alu[i], c_mux[i]);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      total++;
      if (c_done[i] !== 1'b0) begin
        bad++; $display("FAIL rst_done c%0d: got %b need 0", i, c_done[i]);
      end
    end
    test_full_program(-1);
  endtask

  initial begin
    test_reset;
    test_full_program(-1);
    test_stall;
    test_last_address;
    test_early_halt;
    test_full_program(5);
    test_start_in_done;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Microsequencer at the front of the CPU controller: steps a program counter through the 3-bit control ROM, latches each 4-bit control word {alu_sel[1:0], mux_sel, load}, and drives the decoded fields onto the ALU/accumulator datapath. It runs on a start/done handshake, halts on the NOP word (4'b0000) or at the last address, and accepts a datapath stall that holds the current instruction.

## Interface
- ADDR_W, 3, ROM address width / PC width
- WORD_W, 4, control word width (fixed field layout below)
- HALT_WORD, 4'b0000, word that terminates the program (not executed)

- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin program at address 0; sampled only in IDLE
- stall  in  1  hold current EXEC; suppresses load while high
- rom_addr  out  ADDR_W  ROM address (= PC)
- rom_data  in  WORD_W  ROM word, combinational from rom_addr, valid same cycle
- alu_sel  out  2  ALU op: 00 AND, 01 OR, 10 XOR, 11 ADD
- mux_sel  out  1  0 = external operand, 1 = ALU-result feedback
- load  out  1  accumulator write enable, one cycle per executed word
- busy  out  1  high in FETCH/EXEC
- done  out  1  one-cycle pulse on program end

## Operation
- Word layout: [3:2] alu_sel, [1] mux_sel, [0] load.
- States: IDLE, FETCH, EXEC, DONE.
- IDLE: pc=0. start=1 -> FETCH. All other inputs ignored.
- FETCH: instr_q <= rom_data. rom_data==HALT_WORD -> DONE (no EXEC). Otherwise -> EXEC.
- EXEC: alu_sel/mux_sel driven from instr_q. load = instr_q[0] & ~stall.
  - stall=1: stay in EXEC with load=0 and fields held.
  - stall=0: the word executes this cycle. pc==2^ADDR_W-1 -> DONE (no wrap). Otherwise pc <= pc+1, -> FETCH.
- DONE: done=1 for exactly one cycle, then -> IDLE with pc=0.
- start while busy or in DONE: ignored, no restart.
- Word with load=0 and non-halt value: EXEC still takes one cycle, and load stays 0.
- Synchronous reset in any state (including mid-EXEC or under stall): next edge -> IDLE, instr_q=0, pc=0.

## Timing
- Reset values: rom_addr=0, alu_sel=00, mux_sel=0, load=0, busy=0, done=0.
- alu_sel, mux_sel, busy, done and rom_addr are registered or state-decoded. load is combinational from stall in EXEC only.
- With start sampled at edge 0: FETCH addr 0 in cycle 1, EXEC addr 0 in cycle 2. Throughput is 2 cycles per word when there is no stall. Each stall cycle adds 1.
- Halt via HALT_WORD at address k: done is high 2 cycles after the EXEC of address k-1.
- Halt at the last address: done is high the cycle after that EXEC.
- alu_sel/mux_sel outside EXEC: hold the last instr_q value. They are cleared only by reset. Consumers qualify on load.

## Structure
- Package cpu_ctrl_pkg contains:
  - the state enum (IDLE, FETCH, EXEC, DONE);
  - ALU op constants (ALU_AND=2'b00, ALU_OR=2'b01, ALU_XOR=2'b10, ALU_ADD=2'b11);
  - field indices (ALU_SEL_HI=3, ALU_SEL_LO=2, MUX_BIT=1, LOAD_BIT=0);
  - HALT_WORD.
- The existing ROM uses the same field constants.
- One natural sub-module: ctrl_word_decode. It is combinational and maps instr_q to alu_sel/mux_sel/load_raw. The FSM, PC and stall gating stay in cpu_sequencer.

## Test plan
- Reset then idle:
  - Hold rst_n=0 for 2 cycles, then release with start=0 for 5 cycles.
  - Required: all outputs 0, rom_addr=0, busy=0.
- Full program, no stall:
  - ROM = 0001, 1001, 1101, 1111, 1111, 1001, 1101, 0000. Pulse start.
  - Required: 7 load pulses in cycles 2, 4, ..., 14.
  - Required alu_sel/mux_sel per pulse: 00/0, 10/0, 11/0, 11/1, 11/1, 10/0, 11/0.
  - Required: FETCH of addr 7 in cycle 15, done=1 in cycle 16, busy=0 from cycle 16.
- Stall:
  - Same ROM. Assert stall for 3 cycles during the EXEC of addr 3.
  - Required: load=0 while stalled, alu_sel=11 and mux_sel=1 held, exactly one load for addr 3, done delayed to cycle 19.
- Last-address exit:
  - ROM with no halt word (all 8 addresses = 1101).
  - Required: 8 loads, done the cycle after the EXEC of addr 7, pc does not wrap, rom_addr=0 in IDLE.
- Early halt and ignored start:
  - ROM[0]=0000.
  - Required: no load, done in cycle 2.
  - Separately, start pulses during a run change nothing.
- Reset mid-run:
  - rst_n=0 during the EXEC of addr 2 with stall=1.
  - Required: next cycle IDLE, load=0, done is never asserted.
  - A following start runs again from addr 0.
